// File: rtl/fpu_fregfile_sb.sv
// rtl/fpu_fregfile_sb.sv - FP register file with busy scoreboard, write bypass, NaN-boxing and fcsr
module fpu_fregfile_sb #(
    parameter int FLEN = 32,
    parameter int NREG = 32,
    parameter int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RW-1:0]   rs1_sel,
    input  logic [RW-1:0]   rs2_sel,
    input  logic [RW-1:0]   rs3_sel,
    output logic [FLEN-1:0] rs1_data,
    output logic [FLEN-1:0] rs2_data,
    output logic [FLEN-1:0] rs3_data,
    input  logic            issue_valid,
    input  logic [RW-1:0]   issue_rd,
    input  logic            issue_uses_rs3,
    input  logic            issue_multicycle,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    input  logic [FLEN-1:0] wb_data,
    input  logic            wb_sp,
    input  logic [4:0]      wb_flags,
    input  logic            ld_valid,
    input  logic [RW-1:0]   ld_rd,
    input  logic [FLEN-1:0] ld_data,
    input  logic            ld_sp,
    input  logic            csr_we,
    input  logic [1:0]      csr_sel,
    input  logic [7:0]      csr_wdata,
    output logic [7:0]      csr_rdata,
    output logic [2:0]      frm_out,
    output logic [4:0]      fflags_out,
    output logic [NREG-1:0] busy_vec
);

    // Upper-half ones used to NaN-box single-precision values; empty when FLEN=32.
    localparam logic [FLEN-1:0] BOX_MASK =
        (FLEN == 64) ? {{(FLEN/2){1'b1}}, {(FLEN/2){1'b0}}} : '0;

    logic [FLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy, busy_nxt;
    logic [2:0]      frm, frm_nxt;
    logic [4:0]      fflags, fflags_nxt;
    logic [FLEN-1:0] wb_boxed, ld_boxed;
    logic [RW-1:0]   rsel [3];
    logic [FLEN-1:0] rdat [3];
    logic            fire;

    assign wb_boxed = wb_data | (wb_sp ? BOX_MASK : '0);
    assign ld_boxed = ld_data | (ld_sp ? BOX_MASK : '0);

    assign rsel[0]  = rs1_sel;
    assign rsel[1]  = rs2_sel;
    assign rsel[2]  = rs3_sel;
    assign rs1_data = rdat[0];
    assign rs2_data = rdat[1];
    assign rs3_data = rdat[2];

    // wb outranks ld so that a reader sees exactly what the array will hold next cycle.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            if (wb_valid && wb_rd == rsel[p])
                rdat[p] = wb_boxed;
            else if (ld_valid && ld_rd == rsel[p])
                rdat[p] = ld_boxed;
            else
                rdat[p] = regs[rsel[p]];
        end
    end

    assign issue_ready = !(busy[rs1_sel] | busy[rs2_sel] |
                           (issue_uses_rs3 & busy[rs3_sel]) | busy[issue_rd]);
    assign fire        = issue_valid & issue_ready;

    always_comb begin
        busy_nxt = busy;
        if (wb_valid)
            busy_nxt[wb_rd] = 1'b0;
        if (fire && issue_multicycle)
            busy_nxt[issue_rd] = 1'b1;
    end

    always_comb begin
        fflags_nxt = fflags;
        frm_nxt    = frm;
        if (csr_we) begin
            case (csr_sel)
                2'd0: fflags_nxt = csr_wdata[4:0];
                2'd1: frm_nxt    = csr_wdata[2:0];
                2'd2: begin
                    frm_nxt    = csr_wdata[7:5];
                    fflags_nxt = csr_wdata[4:0];
                end
                default: ;
            endcase
        end
        if (wb_valid)
            fflags_nxt = fflags_nxt | wb_flags;
    end

    always_comb begin
        case (csr_sel)
            2'd0:    csr_rdata = {3'b000, fflags};
            2'd1:    csr_rdata = {5'b00000, frm};
            2'd2:    csr_rdata = {frm, fflags};
            default: csr_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy   <= '0;
            frm    <= 3'b000;
            fflags <= 5'b00000;
        end else begin
            if (ld_valid)
                regs[ld_rd] <= ld_boxed;
            if (wb_valid)
                regs[wb_rd] <= wb_boxed;
            busy   <= busy_nxt;
            frm    <= frm_nxt;
            fflags <= fflags_nxt;
        end
    end

    assign frm_out    = frm;
    assign fflags_out = fflags;
    assign busy_vec   = busy;

endmodule
